gray_seq_checker: RTL and testbench
===================================

// Module: gray_seq_checker
// PURPOSE
//   Downstream consumer of the gray-code sequence generator. Samples a free-running
//   standard (reflected) gray code, converts it to binary, and checks that every
//   new sample either holds or advances by exactly +1 (mod 2^DATA_WIDTH).
//   Reports binary value, advance pulses, error pulses, a sticky error flag and a
//   saturating error count. A small FSM handles acquire/re-acquire after reset or error.
// PARAMETERS
//   DATA_WIDTH  4  width of gray input and binary output
//   CNT_WIDTH   8  width of saturating error counter
// PORTS
//   clk         in   1           clock; all state updates on rising edge
//   resetn      in   1           synchronous, active-low reset
//   din         in   DATA_WIDTH  gray-coded input sample, one per cycle
//   clr_err     in   1           clears err_sticky and err_cnt
//   bin_out     out  DATA_WIDTH  binary equivalent of last evaluated sample
//   bin_valid   out  1           bin_out holds a real sample (0 until first evaluation)
//   step        out  1           1-cycle pulse: sample advanced by exactly +1
//   err         out  1           1-cycle pulse: illegal transition detected
//   err_sticky  out  1           set by err, cleared only by clr_err or reset
//   err_cnt     out  CNT_WIDTH   count of err pulses, saturates at 2^CNT_WIDTH-1
//   locked      out  1           1 while FSM is in TRACK
// BEHAVIOUR
//   - Reset (resetn=0 at an edge): every flop incl. sync/pipe flops and valid bits -> 0;
//     all outputs 0; FSM -> ACQ. Reset mid-stream discards in-flight samples.
//   - Pipeline: stage A registers din with a_vld (a_vld=1 on every edge with resetn=1);
//     stage B computes bin = gray2bin(A) (b[i] = ^A[W-1:i]) and registers all outputs.
//     Latency: din before edge N -> outputs valid after edge N+1 (2 cycles).
//   - FSM ACQ: on first stage-B evaluation with a_vld=1: bin_out<=bin, bin_valid<=1,
//     no step, no err -> TRACK. locked=0 in ACQ.
//   - FSM TRACK, per cycle, compare bin with bin_out (previous):
//       bin == prev            -> hold: no pulse, stay TRACK
//       bin == prev+1 mod 2^W  -> step=1, bin_out<=bin, stay TRACK (wrap max->0 legal)
//       anything else (incl -1) -> err=1, bin_out<=bin, err_sticky<=1,
//                                  err_cnt<=sat(err_cnt+1), -> ACQ (next sample re-baselines)
//   - ACQ after error lasts exactly one cycle with stream present; the sample evaluated
//     there is accepted without check; bin_valid stays 1.
//   - clr_err alone: err_sticky<=0, err_cnt<=0. clr_err with same-cycle err: new error wins,
//     err_sticky=1, err_cnt=1.
//   - err_cnt at max + new err: stays at max; err still pulses.
//   - step and err are never 1 in the same cycle.
// CONFIGURATION
//   GRAY_CHK_SYNC_EN defined: two-flop synchronizer (reset to 0) inserted ahead of stage A
//     for asynchronous din; valid bit shifts with it; latency becomes 4 cycles; first
//     evaluation occurs 4 edges after resetn release.
//   Not defined: din taken as synchronous to clk; latency 2 cycles; no sync flops.
// TESTING (DATA_WIDTH=4, CNT_WIDTH=8, macro undefined unless stated)
//   1 reset, din=0,1,3,2,6 one per cycle -> bin_out 0,1,2,3,4 at 2-cycle lat, 4 step, err=0
//   2 drive full 16-value sequence twice -> step on 1000->0000 wrap (bin 15->0), no err
//   3 din 0011 then 0110 (bin 2->4) -> err=1 1 cycle, err_sticky=1, err_cnt=1, locked 0 for
//     1 cycle, next sample 0111 (bin 5) accepted with no step, then 0101 -> step
//   4 hold din=0101 for 5 cycles -> bin_out=6 constant, no step, no err, locked=1
//   5 CNT_WIDTH=2: 5 illegal jumps -> err_cnt=3; then clr_err same cycle as err -> err_cnt=1
//   6 resetn=0 one cycle mid-stream -> all outputs 0; macro defined: bin_valid rises
//     4 edges after release, first sample gives no err

Source files
------------

// File: rtl/gray_seq_checker.sv
// gray_seq_checker: samples a reflected gray-code stream, converts it to binary and
// checks that every new sample either holds or advances by exactly +1 (mod 2^W).
// Reports binary value, step/err pulses, a sticky error flag and a saturating count.
// Build option: define GRAY_CHK_SYNC_EN to add a two-flop synchronizer ahead of
// stage A for an asynchronous din (latency 4 cycles instead of 2).
module gray_seq_checker #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  bin_valid,
  output logic                  step,
  output logic                  err,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  locked
);

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  // Source feeding stage A (either din directly or the synchronizer output)
  logic [DATA_WIDTH-1:0] a_src;
  logic                  a_src_vld;

`ifdef GRAY_CHK_SYNC_EN
  logic [DATA_WIDTH-1:0] sync1_q;
  logic [DATA_WIDTH-1:0] sync2_q;
  logic                  sync1_vld_q;
  logic                  sync2_vld_q;

  // Two-flop synchronizer; the valid bit travels alongside the data
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync1_vld_q <= 1'b0;
      sync2_vld_q <= 1'b0;
    end else begin
      sync1_q     <= din;
      sync2_q     <= sync1_q;
      sync1_vld_q <= 1'b1;
      sync2_vld_q <= sync1_vld_q;
    end
  end

  assign a_src     = sync2_q;
  assign a_src_vld = sync2_vld_q;
`else
  assign a_src     = din;
  assign a_src_vld = 1'b1;
`endif

  logic [DATA_WIDTH-1:0] a_q;
  logic                  a_vld_q;

  // Stage A: register the gray sample and its valid bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q     <= '0;
      a_vld_q <= 1'b0;
    end else begin
      a_q     <= a_src;
      a_vld_q <= a_src_vld;
    end
  end

  logic [DATA_WIDTH-1:0] bin_d;
  logic [DATA_WIDTH-1:0] bin_out_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [CNT_WIDTH-1:0]  err_base;
  logic [CNT_WIDTH-1:0]  err_cnt_d;
  logic                  is_hold;
  logic                  is_step;

  // Gray-to-binary (b[i] = xor of A[W-1:i]) and transition classification;
  // a same-cycle clr_err restarts the count from zero before the new error is added
  always_comb begin
    bin_d = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      bin_d[i] = ^(a_q >> i);
    end
    is_hold   = (bin_d == bin_out_q);
    is_step   = (bin_d == (bin_out_q + DATA_ONE));
    err_base  = clr_err ? '0 : err_cnt_q;
    err_cnt_d = (err_base == CNT_MAX) ? err_base : (err_base + CNT_ONE);
  end

  state_e state_q;
  logic   bin_valid_q;
  logic   step_q;
  logic   err_q;
  logic   err_sticky_q;
  logic   locked_q;

  // Stage B: acquire/track FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ACQ;
      bin_out_q    <= '0;
      bin_valid_q  <= 1'b0;
      step_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      if (clr_err) begin
        err_sticky_q <= 1'b0;
        err_cnt_q    <= '0;
      end
      if (a_vld_q) begin
        case (state_q)
          ACQ: begin
            bin_out_q   <= bin_d;
            bin_valid_q <= 1'b1;
            state_q     <= TRACK;
            locked_q    <= 1'b1;
          end
          TRACK: begin
            if (is_hold) begin
              state_q <= TRACK;
            end else if (is_step) begin
              step_q    <= 1'b1;
              bin_out_q <= bin_d;
            end else begin
              // Later assignments override the clr_err clear above
              err_q        <= 1'b1;
              bin_out_q    <= bin_d;
              err_sticky_q <= 1'b1;
              err_cnt_q    <= err_cnt_d;
              state_q      <= ACQ;
              locked_q     <= 1'b0;
            end
          end
          default: begin
            state_q  <= ACQ;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bin_out    = bin_out_q;
  assign bin_valid  = bin_valid_q;
  assign step       = step_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed bench for gray_seq_checker. Two instances share the stimulus: one with an
// 8-bit error counter and one with a 2-bit counter to exercise saturation.
// Each driven sample carries its hand-computed expected outputs; they are compared
// once that sample has travelled through the pipeline.
module tb_gray_seq_checker;

`ifdef GRAY_CHK_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic       clk;
  logic       resetn;
  logic [3:0] din;
  logic       clr_err;

  logic [3:0] bin_out_8;
  logic       bin_valid_8, step_8, err_8, err_sticky_8, locked_8;
  logic [7:0] err_cnt_8;
  logic [3:0] bin_out_2;
  logic       bin_valid_2, step_2, err_2, err_sticky_2, locked_2;
  logic [1:0] err_cnt_2;

  gray_seq_checker #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .din(din), .clr_err(clr_err),
    .bin_out(bin_out_8), .bin_valid(bin_valid_8), .step(step_8), .err(err_8),
    .err_sticky(err_sticky_8), .err_cnt(err_cnt_8), .locked(locked_8)
  );

  gray_seq_checker #(.DATA_WIDTH(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .resetn(resetn), .din(din), .clr_err(clr_err),
    .bin_out(bin_out_2), .bin_valid(bin_valid_2), .step(step_2), .err(err_2),
    .err_sticky(err_sticky_2), .err_cnt(err_cnt_2), .locked(locked_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       clr;
    logic [3:0] bin;
    logic       stp;
    logic       er;
    logic       sticky;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       lk;
    int         id;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   sample_no = 0;
  bit   fresh = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input int b, input bit clr, input bit stp, input bit er,
                              input bit sticky, input int c8, input int c2, input bit lk);
    exp_t e;
    e.g      = GRAY[b];
    e.clr    = clr;
    e.bin    = 4'(b);
    e.stp    = stp;
    e.er     = er;
    e.sticky = sticky;
    e.c8     = 8'(c8);
    e.c2     = 2'(c2);
    e.lk     = lk;
    e.id     = 0;
    return e;
  endfunction

  task automatic chk_sample(input exp_t e);
    string t;
    t = $sformatf("s%0d", e.id);
    chk({t, ".bin_out"},    32'(bin_out_8),    32'(e.bin));
    chk({t, ".bin_valid"},  32'(bin_valid_8),  32'd1);
    chk({t, ".step"},       32'(step_8),       32'(e.stp));
    chk({t, ".err"},        32'(err_8),        32'(e.er));
    chk({t, ".err_sticky"}, 32'(err_sticky_8), 32'(e.sticky));
    chk({t, ".err_cnt8"},   32'(err_cnt_8),    32'(e.c8));
    chk({t, ".locked"},     32'(locked_8),     32'(e.lk));
    chk({t, ".err_cnt2"},   32'(err_cnt_2),    32'(e.c2));
  endtask

  task automatic chk_zero(input string t);
    chk({t, ".bin_out"},    32'(bin_out_8),    32'd0);
    chk({t, ".bin_valid"},  32'(bin_valid_8),  32'd0);
    chk({t, ".step"},       32'(step_8),       32'd0);
    chk({t, ".err"},        32'(err_8),        32'd0);
    chk({t, ".err_sticky"}, 32'(err_sticky_8), 32'd0);
    chk({t, ".err_cnt8"},   32'(err_cnt_8),    32'd0);
    chk({t, ".locked"},     32'(locked_8),     32'd0);
    chk({t, ".err_cnt2"},   32'(err_cnt_2),    32'd0);
  endtask

  // Drive one sample per cycle; clr_err is aligned to the evaluation cycle of the
  // sample whose expectation asks for it
  task automatic cyc(input exp_t e_in);
    exp_t e;
    exp_t f;
    e    = e_in;
    e.id = sample_no;
    sample_no++;
    q.push_back(e);
    din     = e.g;
    clr_err = (q.size() == LAT) ? q[0].clr : 1'b0;
    tick();
    if (q.size() == LAT) begin
      f = q.pop_front();
      chk_sample(f);
      fresh = 1'b0;
    end else if (fresh) begin
      chk($sformatf("s%0d.pre_valid", e.id),  32'(bin_valid_8), 32'd0);
      chk($sformatf("s%0d.pre_locked", e.id), 32'(locked_8),    32'd0);
    end
  endtask

  initial begin
    resetn  = 1'b0;
    din     = 4'h0;
    clr_err = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    resetn = 1'b1;

    // Acquire then count up 0..4
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(1, 0, 1, 0, 0, 0, 0, 1));
    cyc(mk(2, 0, 1, 0, 0, 0, 0, 1));
    cyc(mk(3, 0, 1, 0, 0, 0, 0, 1));
    cyc(mk(4, 0, 1, 0, 0, 0, 0, 1));

    // Two passes through the full code, both 15->0 wraps are legal steps; ends at bin 2
    for (int k = 5; k <= 34; k++) begin
      cyc(mk(k % 16, 0, 1, 0, 0, 0, 0, 1));
    end

    // 2 -> 4 is illegal; 5 re-baselines without step; 6 steps
    cyc(mk(4, 0, 0, 1, 1, 1, 1, 0));
    cyc(mk(5, 0, 0, 0, 1, 1, 1, 1));
    cyc(mk(6, 0, 1, 0, 1, 1, 1, 1));

    // Hold 0101 for five cycles
    for (int k = 0; k < 5; k++) begin
      cyc(mk(6, 0, 0, 0, 1, 1, 1, 1));
    end

    // Backward step is illegal, then further jumps drive the 2-bit counter to saturation
    cyc(mk(5, 0, 0, 1, 1, 2, 2, 0));
    cyc(mk(5, 0, 0, 0, 1, 2, 2, 1));
    cyc(mk(9, 0, 0, 1, 1, 3, 3, 0));
    cyc(mk(9, 0, 0, 0, 1, 3, 3, 1));
    cyc(mk(0, 0, 0, 1, 1, 4, 3, 0));
    cyc(mk(0, 0, 0, 0, 1, 4, 3, 1));
    cyc(mk(7, 0, 0, 1, 1, 5, 3, 0));
    cyc(mk(7, 0, 0, 0, 1, 5, 3, 1));

    // clr_err alone, then clr_err together with a new error
    cyc(mk(7,  1, 0, 0, 0, 0, 0, 1));
    cyc(mk(7,  0, 0, 0, 0, 0, 0, 1));
    cyc(mk(12, 1, 0, 1, 1, 1, 1, 0));
    cyc(mk(12, 0, 0, 0, 1, 1, 1, 1));
    cyc(mk(13, 0, 1, 0, 1, 1, 1, 1));
    cyc(mk(14, 0, 1, 0, 1, 1, 1, 1));

    // Reset mid-stream discards the in-flight sample
    din     = GRAY[3];
    clr_err = 1'b0;
    resetn  = 1'b0;
    tick();
    chk_zero("midreset");
    q.delete();
    fresh  = 1'b1;
    resetn = 1'b1;

    // First sample after release is accepted with no error
    cyc(mk(4, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(5, 0, 1, 0, 0, 0, 0, 1));
    cyc(mk(5, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(6, 0, 1, 0, 0, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
